matrix_link_receiver: RTL

- Receive-side counterpart of the matrix output path: deserializes the multi-channel SPI column stream (spi_clk + CHANNEL_NUMBER MOSI lines) and decodes the column-select shift-register interface (ser_clk/ser_data/ser_stcp/ser_n_enable).
- Used as a loopback checker in the FPGA test project and as the bench-side model of the CH32V003 matrix controllers.
- All link inputs are asynchronous to clk and are oversampled. clk must be at least 4x spi_clk and ser_clk.

---
 rtl/matrix_link_receiver.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/matrix_link_receiver.sv
// matrix_link_receiver
// Receive side of the matrix output link. Oversamples the multi-channel SPI
// column stream and the 595-style column-select interface, deserializes one
// word per channel, and mirrors the latched column pattern.
// Optional build macro: MATRIX_LINK_RX_TIMEOUT_EN (drops a stalled partial word).
module matrix_link_receiver #(
  parameter int CHANNEL_NUMBER = 3,
  parameter int SPI_SIZE       = 8,
  parameter int MSB_FIRST      = 1,
  parameter int COLUMN_NUMBER  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               spi_clk,
  input  logic [CHANNEL_NUMBER-1:0]          spi_mosi,
  input  logic                               ser_clk,
  input  logic                               ser_data,
  input  logic                               ser_stcp,
  input  logic                               ser_n_enable,
  input  logic                               rx_ready,
  input  logic                               err_clr,
  output logic [CHANNEL_NUMBER*SPI_SIZE-1:0] rx_data,
  output logic                               rx_valid,
  output logic                               rx_overrun,
  output logic                               rx_partial,
  output logic [COLUMN_NUMBER-1:0]           column_reg,
  output logic                               column_strobe,
  output logic                               frame_start,
  output logic [15:0]                        word_count,
  output logic                               outputs_enabled
);

  localparam int DATA_W = CHANNEL_NUMBER * SPI_SIZE;
  localparam int CNT_W  = $clog2(SPI_SIZE + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Synchronizer stages and delayed copies for edge detection
  logic                      spi_s1, spi_s2, spi_d;
  logic [CHANNEL_NUMBER-1:0] mosi_s1, mosi_s2;
  logic                      sclk_s1, sclk_s2, sclk_d;
  logic                      sdat_s1, sdat_s2;
  logic                      stcp_s1, stcp_s2, stcp_d;
  logic                      n_en_s1, n_en_s2;

  // Registered edge events with the data bits aligned to them
  logic                      spi_ev, ser_ev, stcp_ev;
  logic [CHANNEL_NUMBER-1:0] mosi_q;
  logic                      sdat_q;

  // Deserializer state
  logic [0:0]                state;
  logic [CNT_W-1:0]          bit_cnt;
  logic [DATA_W-1:0]         shift_q;
  logic [DATA_W-1:0]         shift_nxt;
  logic [COLUMN_NUMBER-1:0]  col_shift;

  logic bit_last, word_done, drop_partial, timeout_hit;

  // Two-flop synchronizers, then a registered rising-edge detector per clock-like input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_s1  <= 1'b0;
      spi_s2  <= 1'b0;
      spi_d   <= 1'b0;
      mosi_s1 <= '0;
      mosi_s2 <= '0;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      sdat_s1 <= 1'b0;
      sdat_s2 <= 1'b0;
      stcp_s1 <= 1'b0;
      stcp_s2 <= 1'b0;
      stcp_d  <= 1'b0;
      // NOTE: the enable synchronizer resets to "disabled" (1) so that
      // outputs_enabled, its inverse, reads 0 in reset like every other output.
      n_en_s1 <= 1'b1;
      n_en_s2 <= 1'b1;
      spi_ev  <= 1'b0;
      ser_ev  <= 1'b0;
      stcp_ev <= 1'b0;
      mosi_q  <= '0;
      sdat_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this into a shift chain.
      spi_s1  <= spi_clk;
      spi_s2  <= spi_s1;
      spi_d   <= spi_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
      sclk_s1 <= ser_clk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      sdat_s1 <= ser_data;
      sdat_s2 <= sdat_s1;
      stcp_s1 <= ser_stcp;
      stcp_s2 <= stcp_s1;
      stcp_d  <= stcp_s2;
      n_en_s1 <= ser_n_enable;
      n_en_s2 <= n_en_s1;
      spi_ev  <= spi_s2 & ~spi_d;
      ser_ev  <= sclk_s2 & ~sclk_d;
      stcp_ev <= stcp_s2 & ~stcp_d;
      mosi_q  <= mosi_s2;
      sdat_q  <= sdat_s2;
    end
  end

  assign outputs_enabled = ~n_en_s2;

  // Per-channel next shift value: new bit enters at the LSB (MSB first) or MSB (LSB first)
  for (genvar c = 0; c < CHANNEL_NUMBER; c++) begin : g_ch
    if (SPI_SIZE == 1) begin : g_single
      assign shift_nxt[c] = mosi_q[c];
    end else if (MSB_FIRST != 0) begin : g_msb
      assign shift_nxt[c*SPI_SIZE +: SPI_SIZE] =
        {shift_q[c*SPI_SIZE +: SPI_SIZE-1], mosi_q[c]};
    end else begin : g_lsb
      assign shift_nxt[c*SPI_SIZE +: SPI_SIZE] =
        {mosi_q[c], shift_q[c*SPI_SIZE+1 +: SPI_SIZE-1]};
    end
  end

  // Word boundary decode; a completing edge takes priority over a latch-edge drop
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    bit_last     = (bit_cnt == CNT_W'(SPI_SIZE - 1));
    word_done    = spi_ev && bit_last;
    drop_partial = stcp_ev && (state == ST_SHIFT) && !word_done;
  end

`ifdef MATRIX_LINK_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (state == ST_SHIFT) && !spi_ev && (to_cnt == TO_W'(TIMEOUT_CYCLES));

  // Inactivity counter: runs only while a word is in progress, restarts on each spi edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if ((state != ST_SHIFT) || spi_ev || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit           = 1'b0;
`endif

  // Deserializer FSM: IDLE until the first edge, SHIFT while a word is incomplete
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shift register is reset too so a fresh word never exposes
      // bits left over from before reset.
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
    end else if (drop_partial || timeout_hit) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
    end else if (spi_ev) begin
      shift_q <= shift_nxt;
      if (bit_last) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
      end else begin
        state   <= ST_SHIFT;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  // Output word register with valid/ready handshake, sticky errors and word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_partial <= 1'b0;
      word_count <= '0;
    end else begin
      if (word_done) begin
        rx_data  <= shift_nxt;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (word_done && rx_valid && !rx_ready) begin
        rx_overrun <= 1'b1;
      end else if (err_clr) begin
        rx_overrun <= 1'b0;
      end

      if (drop_partial || timeout_hit) begin
        rx_partial <= 1'b1;
      end else if (err_clr) begin
        rx_partial <= 1'b0;
      end

      if (stcp_ev) begin
        word_count <= '0;
      end else if (word_done && (word_count != 16'hFFFF)) begin
        word_count <= word_count + 16'd1;
      end
    end
  end

  // Column shift register and storage latch; the latch sees the pre-shift value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_shift     <= '0;
      column_reg    <= '0;
      column_strobe <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      if (ser_ev) begin
        col_shift <= {col_shift[COLUMN_NUMBER-2:0], sdat_q};
      end
      if (stcp_ev) begin
        column_reg <= col_shift;
      end
      column_strobe <= stcp_ev;
      frame_start   <= stcp_ev && (col_shift == COLUMN_NUMBER'(1));
    end
  end

endmodule
